// File: rtl/warp_instruction_fetch_pkg.sv
// Shared types and constants for the warp instruction fetch unit and its helpers.
package warp_instruction_fetch_pkg;

  localparam int NUM_WARPS = 32;
  localparam int WARP_ID_W = 5;
  localparam int ERR_W     = 4;

  typedef enum logic [1:0] {
    IFU_IDLE,
    IFU_REQ,
    IFU_WAIT,
    IFU_EMIT
  } ifu_state_t;

  localparam int KIANA_IFU_ERR_RSP_UNEXPECTED   = 0;
  localparam int KIANA_IFU_ERR_LAUNCH_ACTIVE    = 1;
  localparam int KIANA_IFU_ERR_PC_WRITE_PENDING = 2;
  localparam int KIANA_IFU_ERR_REQ_BUSY         = 3;

  function automatic logic [NUM_WARPS-1:0] warp_onehot(input logic [WARP_ID_W-1:0] id);
    return NUM_WARPS'(1) << id;
  endfunction

endpackage

// File: rtl/warp_priority_encoder.sv
// Lowest-set-bit encoder over a warp mask; shared with the warp scheduler.
module warp_priority_encoder
  import warp_instruction_fetch_pkg::*;
(
  input  logic [NUM_WARPS-1:0] i_mask,
  output logic [WARP_ID_W-1:0] o_idx,
  output logic                 o_any
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_idx = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      if (i_mask[i]) o_idx = WARP_ID_W'(i);
    end
  end

  assign o_any = |i_mask;

endmodule

// File: rtl/warp_instruction_fetch.sv
// Per-warp instruction fetch: walks a fetch mask lowest-warp-first and owns the PC table.
// Optional KIANA_IFU_PC_OUT_EN adds m_pc_dec and a shadow of each warp's last-fetched PC.
module warp_instruction_fetch
  import warp_instruction_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_tvalid_ib,
  input  logic [NUM_WARPS-1:0] s_warp_fetch_mask,
  output logic                 m_tready_ib,
  output logic                 m_mem_req_valid,
  output logic [ADDR_W-1:0]    m_mem_req_addr,
  input  logic                 s_mem_req_ready,
  input  logic                 s_mem_rsp_valid,
  input  logic [INST_W-1:0]    s_mem_rsp_data,
  output logic                 m_tvalid_dec,
  output logic                 m_tlast_dec,
  output logic                 m_tabort_dec,
  output logic [WARP_ID_W-1:0] m_warp_id_dec,
  output logic [INST_W-1:0]    m_inst_dec,
  input  logic                 s_tvalid_launch,
  input  logic [WARP_ID_W-1:0] launch_warp_id,
  input  logic [ADDR_W-1:0]    launch_pc,
  input  logic                 s_tvalid_pc,
  input  logic [WARP_ID_W-1:0] pc_warp_id,
  input  logic [ADDR_W-1:0]    pc_value,
  input  logic                 s_tvalid_exit,
  input  logic [WARP_ID_W-1:0] exit_warp_id,
  output logic [NUM_WARPS-1:0] active_mask,
`ifdef KIANA_IFU_PC_OUT_EN
  output logic [ADDR_W-1:0]    m_pc_dec,
`endif
  output logic                 err
);

  ifu_state_t             r_state, w_state_nxt;
  logic [NUM_WARPS-1:0]   r_pending, w_pending_nxt, r_active;
  logic [WARP_ID_W-1:0]   r_cur;
  logic [ADDR_W-1:0]      r_addr;
  logic [INST_W-1:0]      r_inst;
  logic [ADDR_W-1:0]      r_pc [NUM_WARPS];
  logic                   r_abort, w_abort_nxt;
  logic [ERR_W-1:0]       r_err, w_err_set;
  logic                   w_load_cur, w_emit, w_capture;

  logic [NUM_WARPS-1:0]   w_exit_onehot, w_launch_onehot, w_cur_onehot;
  logic [NUM_WARPS-1:0]   w_accept_mask, w_pend_after_emit, w_enc_in;
  logic [WARP_ID_W-1:0]   w_enc_idx;
  logic                   w_enc_any;

  assign w_exit_onehot     = s_tvalid_exit   ? warp_onehot(exit_warp_id)   : '0;
  assign w_launch_onehot   = s_tvalid_launch ? warp_onehot(launch_warp_id) : '0;
  assign w_cur_onehot      = warp_onehot(r_cur);
  assign w_accept_mask     = s_warp_fetch_mask & r_active & ~w_exit_onehot;
  assign w_pend_after_emit = r_pending & ~w_cur_onehot & ~w_exit_onehot;
  assign w_enc_in          = (r_state == IFU_IDLE) ? w_accept_mask : w_pend_after_emit;

  warp_priority_encoder u_enc (
    .i_mask (w_enc_in),
    .o_idx  (w_enc_idx),
    .o_any  (w_enc_any)
  );

  // NOTE: state and data registers use non-blocking assignments; next-state logic is blocking in always_comb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IFU_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    // An exiting warp leaves pending unless it is the one already being fetched.
    w_pending_nxt   = r_pending & ~(w_exit_onehot & ~w_cur_onehot);
    w_load_cur      = 1'b0;
    w_emit          = 1'b0;
    w_capture       = 1'b0;
    w_abort_nxt     = 1'b0;
    m_tready_ib     = 1'b0;
    m_mem_req_valid = 1'b0;
    m_tvalid_dec    = 1'b0;
    m_tlast_dec     = 1'b0;
    case (r_state)
      IFU_IDLE: begin
        // Gated by rst_n so every output reads 0 while reset is held.
        m_tready_ib   = rst_n;
        w_pending_nxt = '0;
        if (s_tvalid_ib) begin
          if (w_enc_any) begin
            w_pending_nxt = w_accept_mask;
            w_load_cur    = 1'b1;
            w_state_nxt   = IFU_REQ;
          end else begin
            w_abort_nxt   = 1'b1;
          end
        end
      end
      IFU_REQ: begin
        m_mem_req_valid = 1'b1;
        if (s_mem_req_ready) w_state_nxt = IFU_WAIT;
      end
      IFU_WAIT: begin
        if (s_mem_rsp_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = IFU_EMIT;
        end
      end
      IFU_EMIT: begin
        m_tvalid_dec  = 1'b1;
        w_emit        = 1'b1;
        w_pending_nxt = w_pend_after_emit;
        if (w_enc_any) begin
          w_load_cur  = 1'b1;
          w_state_nxt = IFU_REQ;
        end else begin
          m_tlast_dec = 1'b1;
          w_state_nxt = IFU_IDLE;
        end
      end
      default: w_state_nxt = IFU_IDLE;
    endcase
  end

  always_comb begin
    w_err_set = '0;
    w_err_set[KIANA_IFU_ERR_RSP_UNEXPECTED]   = s_mem_rsp_valid && (r_state != IFU_WAIT);
    w_err_set[KIANA_IFU_ERR_LAUNCH_ACTIVE]    = s_tvalid_launch && r_active[launch_warp_id];
    w_err_set[KIANA_IFU_ERR_PC_WRITE_PENDING] = s_tvalid_pc && r_pending[pc_warp_id];
    w_err_set[KIANA_IFU_ERR_REQ_BUSY]         = s_tvalid_ib && (r_state != IFU_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_active  <= '0;
      r_cur     <= '0;
      r_addr    <= '0;
      r_inst    <= '0;
      r_abort   <= 1'b0;
      r_err     <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_active  <= (r_active & ~w_exit_onehot) | w_launch_onehot;
      r_abort   <= w_abort_nxt;
      r_err     <= r_err | w_err_set;
      if (w_load_cur) begin
        r_cur  <= w_enc_idx;
        r_addr <= r_pc[w_enc_idx];
      end
      if (w_capture) r_inst <= s_mem_rsp_data;
    end
  end

  // NOTE: the PC table is a register array with a real reset, since warps may be read before launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) r_pc[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (s_tvalid_launch && launch_warp_id == WARP_ID_W'(w))
          r_pc[w] <= launch_pc;
        else if (s_tvalid_pc && pc_warp_id == WARP_ID_W'(w))
          r_pc[w] <= pc_value;
        else if (w_emit && r_cur == WARP_ID_W'(w))
          r_pc[w] <= r_pc[w] + ADDR_W'(4);
      end
    end
  end

`ifdef KIANA_IFU_PC_OUT_EN
  logic [ADDR_W-1:0] r_shadow [NUM_WARPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) r_shadow[w] <= '0;
    end else if (m_mem_req_valid && s_mem_req_ready) begin
      r_shadow[r_cur] <= r_addr;
    end
  end

  assign m_pc_dec = m_tvalid_dec ? r_shadow[r_cur] : '0;
`endif

  assign m_mem_req_addr = m_mem_req_valid ? r_addr : '0;
  assign m_warp_id_dec  = m_tvalid_dec ? r_cur : '0;
  assign m_inst_dec     = m_tvalid_dec ? r_inst : '0;
  assign m_tabort_dec   = r_abort;
  assign active_mask    = r_active;
  assign err            = |r_err;

endmodule
